// File: rtl/mips_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// Operation and FSM encodings live here so the control and datapath files agree.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITERS = MD_WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add into {rem, quo}. Divide: restoring shift-subtract.
module md_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum     = {1'b0, rem_i} + (quo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {rem_i, quo_i[WIDTH-1]};
    fits    = shifted >= {1'b0, opb_i};
    // When the trial subtract fits, the result is below the divisor, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - opb_i;

    if (div_i) begin
      rem_o = fits ? diff : shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], fits};
    end else begin
      rem_o = sum[WIDTH:1];
      quo_o = {sum[0], quo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Works on operand magnitudes for WIDTH cycles, then applies signs on the final write.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  md_op_e           op_e;
  logic             op_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_e   = md_op_e'(op);
  assign op_sgn = md_is_signed(op_e);
  assign a_neg  = op_sgn & a[WIDTH-1];
  assign b_neg  = op_sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  md_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_i (div_q),
    .rem_i (rem_q),
    .quo_i (quo_q),
    .opb_i (opb_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Sign fix-up on the final iteration's output, feeding the HI/LO write directly.
  always_comb begin
    prod     = {step_rem, step_quo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -step_quo : step_quo;
    rem_fix  = rneg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      MD_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d = MD_RUN;
          cnt_d   = '0;
          div_d   = md_is_div(op_e);
          rem_d   = '0;
          rneg_d  = a_neg;
          if (md_is_div(op_e)) begin
            quo_d = a_mag;
            opb_d = b_mag;
            // Divide by zero keeps the unsigned all-ones quotient; the remainder
            // naturally reconstructs the raw dividend once its sign is restored.
            neg_d = (a_neg ^ b_neg) && (b != '0);
          end else begin
            quo_d = b_mag;
            opb_d = a_mag;
            neg_d = a_neg ^ b_neg;
          end
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = MD_FIN;
            if (div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      MD_FIN: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = (state_q == MD_FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
